// File: rtl/br_pkg.sv
// rtl/br_pkg.sv - shared flow-op, state and target-table definitions for branch_ctrl
package br_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_JMP  = 3'd1,
        OP_BEQZ = 3'd2,
        OP_BNEZ = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5,
        OP_HALT = 3'd6
    } br_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } br_state_t;

    localparam int LUT_W = 12;

    // Absolute branch targets, narrowed or zero-extended to D by the user.
    function automatic logic [LUT_W-1:0] br_lut(input logic [3:0] idx);
        logic [LUT_W-1:0] v;
        case (idx)
            4'd0:    v = 12'h200;
            4'd1:    v = 12'h010;
            4'd2:    v = 12'h020;
            4'd3:    v = 12'h040;
            4'd4:    v = 12'h080;
            4'd5:    v = 12'h100;
            4'd6:    v = 12'h180;
            4'd7:    v = 12'h300;
            4'd8:    v = 12'h400;
            4'd9:    v = 12'h555;
            4'd10:   v = 12'h7FF;
            4'd11:   v = 12'h800;
            4'd12:   v = 12'hA00;
            4'd13:   v = 12'hC00;
            4'd14:   v = 12'hE00;
            default: v = 12'hFFF;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - LIFO of return addresses; push has priority over pop
module ret_stack #(
    parameter int D      = 12,
    parameter int SDEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [D-1:0] push_data,
    output logic [D-1:0] top,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(SDEPTH + 1);
    localparam int IW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

    logic [D-1:0]  r_mem [SDEPTH];
    logic [PW-1:0] r_ptr;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_top_idx;

    assign w_wr_idx  = IW'(r_ptr);
    assign w_top_idx = IW'(r_ptr - PW'(1));
    assign full      = (r_ptr == PW'(SDEPTH));
    assign empty     = (r_ptr == '0);
    assign top       = r_mem[w_top_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (push && !full) begin
            r_ptr <= r_ptr + PW'(1);
        end else if (pop && !empty) begin
            r_ptr <= r_ptr - PW'(1);
        end
    end

    // Storage needs no reset; the pointer alone defines validity.
    always_ff @(posedge clk) begin
        if (!reset && push && !full) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - program-flow controller producing relative PC jumps
module branch_ctrl
    import br_pkg::*;
#(
    parameter int D      = 12,
    parameter int SDEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [D-1:0] prog_ctr,
    input  br_op_t       op,
    input  logic [3:0]   lut_idx,
    input  logic         zero,
    output logic         jump_en,
    output logic [D-1:0] target,
    output logic         done,
    output logic         stack_err
);
    br_state_t    r_state;
    br_state_t    w_next_state;
    logic         r_err;
    logic         w_set_err;
    logic         w_push;
    logic         w_pop;
    logic [D-1:0] w_abs;
    logic [D-1:0] w_top;
    logic         w_full;
    logic         w_empty;

    assign w_abs = D'(br_lut(lut_idx));

    ret_stack #(.D(D), .SDEPTH(SDEPTH)) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (prog_ctr + D'(1)),
        .top       (w_top),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_err   <= r_err | w_set_err;
        end
    end

    // Holding the PC is expressed as a taken jump of offset zero.
    always_comb begin
        w_next_state = r_state;
        jump_en      = 1'b1;
        target       = '0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_set_err    = 1'b0;
        if (r_state == ST_RUN) begin
            case (op)
                OP_JMP:  target = w_abs - prog_ctr;
                OP_BEQZ: if (zero) target = w_abs - prog_ctr; else jump_en = 1'b0;
                OP_BNEZ: if (!zero) target = w_abs - prog_ctr; else jump_en = 1'b0;
                OP_CALL: begin
                    if (!w_full) begin
                        w_push = 1'b1;
                        target = w_abs - prog_ctr;
                    end else begin
                        jump_en   = 1'b0;
                        w_set_err = 1'b1;
                    end
                end
                OP_RET: begin
                    if (!w_empty) begin
                        w_pop  = 1'b1;
                        target = w_top - prog_ctr;
                    end else begin
                        jump_en   = 1'b0;
                        w_set_err = 1'b1;
                    end
                end
                OP_HALT: w_next_state = ST_HALT;
                default: jump_en = 1'b0;
            endcase
        end else if (start) begin
            target       = '0 - prog_ctr;
            w_next_state = ST_RUN;
        end
    end

    assign done      = (r_state == ST_HALT);
    assign stack_err = r_err;

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - self-checking bench for branch_ctrl
module tb_branch_ctrl;
    import br_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, zero;
    logic [11:0] prog_ctr;
    br_op_t      op;
    logic [3:0]  lut_idx;
    logic        jump_en, done, stack_err;
    logic [11:0] target;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    branch_ctrl #(.D(12), .SDEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .prog_ctr(prog_ctr), .op(op),
        .lut_idx(lut_idx), .zero(zero), .jump_en(jump_en), .target(target),
        .done(done), .stack_err(stack_err)
    );

    logic [11:0] tbl [16] = '{12'h200, 12'h010, 12'h020, 12'h040, 12'h080, 12'h100,
                              12'h180, 12'h300, 12'h400, 12'h555, 12'h7FF, 12'h800,
                              12'hA00, 12'hC00, 12'hE00, 12'hFFF};

    typedef struct {
        logic        rst, st;
        br_op_t      op;
        logic [3:0]  idx;
        logic        z;
        logic [11:0] pc;
        logic        chk, chk_t, ej;
        logic [11:0] et;
        logic        ed, ee;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic st, br_op_t o, logic [3:0] idx, logic z,
                                logic [11:0] pc, logic chk, logic chk_t, logic ej,
                                logic [11:0] et, logic ed, logic ee);
        vec_t v;
        v.rst = rst; v.st = st; v.op = o; v.idx = idx; v.z = z; v.pc = pc;
        v.chk = chk; v.chk_t = chk_t; v.ej = ej; v.et = et; v.ed = ed; v.ee = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%03h expected 0x%03h at %0t", name, got, exp, $time);
    endtask

    task automatic drive(input logic rst, input logic st, input br_op_t o, input logic [3:0] idx,
                         input logic z, input logic [11:0] pc);
        reset = rst; start = st; op = o; lut_idx = idx; zero = z; prog_ctr = pc;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic ej, input logic chk_t,
                              input logic [11:0] et, input logic ed, input logic ee);
        @(negedge clk);
        check({tag, ".jump_en"}, {11'd0, jump_en}, {11'd0, ej});
        if (chk_t) check({tag, ".target"}, target, et);
        check({tag, ".done"}, {11'd0, done}, {11'd0, ed});
        check({tag, ".stack_err"}, {11'd0, stack_err}, {11'd0, ee});
    endtask

    // Reference model state, kept as plain flags and a queue.
    bit          m_run, m_halt, m_err;
    logic [11:0] m_stk[$];

    initial begin
        drive(1'b1, 1'b0, OP_NOP, 4'd0, 1'b0, 12'h000);
        next_cycle();
        next_cycle();

        // Directed table: start, branches, call/return, underflow, overflow.
        vecs.push_back(mk(0,0,OP_JMP ,3,0,12'h010, 1,1,1,12'h000,0,0));
        vecs.push_back(mk(0,1,OP_NOP ,0,0,12'h000, 1,1,1,12'h000,0,0));
        vecs.push_back(mk(0,0,OP_NOP ,0,0,12'h000, 1,0,0,12'h000,0,0));
        vecs.push_back(mk(0,1,OP_NOP ,0,0,12'h001, 1,0,0,12'h000,0,0));
        vecs.push_back(mk(0,0,OP_BEQZ,3,1,12'h010, 1,1,1,12'h030,0,0));
        vecs.push_back(mk(0,0,OP_BEQZ,3,0,12'h010, 1,0,0,12'h000,0,0));
        vecs.push_back(mk(0,0,OP_BNEZ,3,0,12'h010, 1,1,1,12'h030,0,0));
        vecs.push_back(mk(0,0,OP_BNEZ,3,1,12'h010, 1,0,0,12'h000,0,0));
        vecs.push_back(mk(0,0,OP_JMP ,5,0,12'hF00, 1,1,1,12'h200,0,0));
        vecs.push_back(mk(0,0,OP_CALL,5,0,12'h020, 1,1,1,12'h0E0,0,0));
        vecs.push_back(mk(0,0,OP_RET ,0,0,12'h105, 1,1,1,12'hF1C,0,0));
        vecs.push_back(mk(0,0,OP_RET ,0,0,12'h050, 1,0,0,12'h000,0,0));
        vecs.push_back(mk(0,0,OP_NOP ,0,0,12'h051, 1,0,0,12'h000,0,1));
        vecs.push_back(mk(0,1,OP_NOP ,0,0,12'h052, 1,0,0,12'h000,0,1));
        vecs.push_back(mk(1,0,OP_NOP ,0,0,12'h000, 0,0,0,12'h000,0,0));
        vecs.push_back(mk(0,1,OP_NOP ,0,0,12'h123, 1,1,1,12'hEDD,0,0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0,0,OP_CALL,0,0,12'h300 + 12'(i), 1,1,1,12'hF00 - 12'(i),0,0));
        vecs.push_back(mk(0,0,OP_CALL,0,0,12'h304, 1,0,0,12'h000,0,0));
        vecs.push_back(mk(0,0,OP_RET ,0,0,12'h400, 1,1,1,12'hF04,0,1));
        vecs.push_back(mk(1,0,OP_NOP ,0,0,12'h000, 0,0,0,12'h000,0,0));
        vecs.push_back(mk(0,1,OP_NOP ,0,0,12'h000, 1,1,1,12'h000,0,0));
        vecs.push_back(mk(0,0,OP_RET ,0,0,12'h001, 1,0,0,12'h000,0,0));
        vecs.push_back(mk(0,0,OP_NOP ,0,0,12'h002, 1,0,0,12'h000,0,1));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].st, vecs[i].op, vecs[i].idx, vecs[i].z, vecs[i].pc);
            if (vecs[i].chk)
                expect_out($sformatf("vec%0d", i), vecs[i].ej, vecs[i].chk_t,
                           vecs[i].et, vecs[i].ed, vecs[i].ee);
            next_cycle();
        end

        // Halt, hold for 10 cycles ignoring ops, then restart.
        drive(1'b1, 1'b0, OP_NOP, 0, 0, 12'h000); next_cycle();
        drive(1'b0, 1'b1, OP_NOP, 0, 0, 12'h000); next_cycle();
        drive(1'b0, 1'b0, OP_HALT, 0, 0, 12'h0FF);
        expect_out("halt_entry", 1'b1, 1'b1, 12'h000, 1'b0, 1'b0);
        next_cycle();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, (i % 2 == 0) ? OP_RET : OP_JMP, 4'(i), 0, 12'h0FF);
            expect_out($sformatf("halt_hold%0d", i), 1'b1, 1'b1, 12'h000, 1'b1, 1'b0);
            next_cycle();
        end
        drive(1'b0, 1'b1, OP_NOP, 0, 0, 12'h0FF);
        expect_out("restart", 1'b1, 1'b1, 12'hF01, 1'b1, 1'b0);
        next_cycle();
        drive(1'b0, 1'b0, OP_NOP, 0, 0, 12'h000);
        expect_out("restart_run", 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
        next_cycle();

        // Reset aborting RUN with two stack entries and a set error flag.
        drive(1'b0, 1'b0, OP_RET, 0, 0, 12'h001); next_cycle();
        drive(1'b0, 1'b0, OP_CALL, 2, 0, 12'h002); next_cycle();
        drive(1'b0, 1'b0, OP_CALL, 4, 0, 12'h020); next_cycle();
        drive(1'b1, 1'b1, OP_CALL, 4, 0, 12'h080); next_cycle();
        drive(1'b0, 1'b0, OP_NOP, 0, 0, 12'h081);
        expect_out("abort_idle", 1'b1, 1'b1, 12'h000, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 1'b1, OP_NOP, 0, 0, 12'h000); next_cycle();
        drive(1'b0, 1'b0, OP_RET, 0, 0, 12'h005);
        expect_out("abort_empty", 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
        next_cycle();

        // Randomized run against the reference model.
        drive(1'b1, 1'b0, OP_NOP, 0, 0, 12'h000); next_cycle();
        m_run = 0; m_halt = 0; m_err = 0; m_stk.delete();
        for (int n = 0; n < 600; n++) begin
            logic        r, s, z, ej, set_err;
            br_op_t      o;
            logic [3:0]  idx;
            logic [11:0] pc, et, ab;
            r   = ($urandom_range(0, 63) == 0);
            s   = ($urandom_range(0, 7) == 0);
            o   = br_op_t'(3'($urandom_range(0, 6)));
            idx = 4'($urandom_range(0, 15));
            z   = 1'($urandom_range(0, 1));
            pc  = 12'($urandom);
            drive(r, s, o, idx, z, pc);
            ab = tbl[idx];
            ej = 1; et = 0; set_err = 0;
            if (!m_run) begin
                if (s) et = 12'h000 - pc;
            end else begin
                case (o)
                    OP_JMP:  et = ab - pc;
                    OP_BEQZ: begin ej = z;  et = z ? ab - pc : 0; end
                    OP_BNEZ: begin ej = !z; et = !z ? ab - pc : 0; end
                    OP_CALL: if (m_stk.size() < 4) et = ab - pc;
                             else begin ej = 0; set_err = 1; end
                    OP_RET:  if (m_stk.size() > 0) et = m_stk[$] - pc;
                             else begin ej = 0; set_err = 1; end
                    OP_HALT: et = 0;
                    default: ej = 0;
                endcase
            end
            if (!r) expect_out($sformatf("rnd%0d", n), ej, ej, et, m_halt, m_err);
            if (r) begin
                m_run = 0; m_halt = 0; m_err = 0; m_stk.delete();
            end else if (!m_run) begin
                if (s) begin m_run = 1; m_halt = 0; end
            end else begin
                m_err = m_err | set_err;
                if (o == OP_CALL && m_stk.size() < 4) m_stk.push_back(pc + 12'd1);
                else if (o == OP_RET && m_stk.size() > 0) void'(m_stk.pop_back());
                else if (o == OP_HALT) begin m_run = 0; m_halt = 1; end
            end
            next_cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameter D, default 12, giving the program-address width.
REQ-002 SHALL have parameter SDEPTH, default 4, giving the return-stack depth in entries.
REQ-003 SHALL have port clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: one-cycle pulse that begins execution from address 0.
REQ-006 SHALL have port prog_ctr, input, D bits: the current program counter, fed back from the PC.
REQ-007 SHALL have port op, input, 3 bits: decoded flow op (br_op_t): NOP, JMP, BEQZ, BNEZ, CALL, RET, HALT.
REQ-008 SHALL have port lut_idx, input, 4 bits: index into the 16-entry absolute target table.
REQ-009 SHALL have port zero, input, 1 bit: ALU zero flag for the current instruction.
REQ-010 SHALL have port jump_en, output, 1 bit: to PC; 1 means PC <= PC + target.
REQ-011 SHALL have port target, output, D bits: relative offset to PC, modulo 2^D.
REQ-012 SHALL have port done, output, 1 bit: high while in HALT.
REQ-013 SHALL have port stack_err, output, 1 bit: sticky flag for return-stack overflow or underflow.

Function
REQ-014 SHALL implement states IDLE, RUN and HALT.
REQ-015 SHALL make jump_en and target combinational from the state, op, zero, prog_ctr and stack top, with zero latency into the PC's next edge.
REQ-016 SHALL, in IDLE and HALT, drive jump_en=1 and target=0 so the PC holds.
REQ-017 SHALL, on start in IDLE or HALT, drive jump_en=1 and target=(0 - prog_ctr) mod 2^D, and enter RUN on the next edge.
REQ-018 SHALL ignore start while in RUN.
REQ-019 SHALL define abs = LUT[lut_idx]; a taken JMP/BEQZ/BNEZ/CALL SHALL drive target = (abs - prog_ctr) mod 2^D with jump_en=1.
REQ-020 SHALL always take JMP.
REQ-021 SHALL take BEQZ only when zero=1, and BNEZ only when zero=0.
REQ-022 SHALL, for an untaken branch or NOP, drive jump_en=0 so the PC increments by 1.
REQ-023 SHALL, on CALL with the stack not full, push (prog_ctr+1) mod 2^D and jump.
REQ-024 SHALL, on CALL with the stack full (SDEPTH entries), not push, not jump, and set stack_err.
REQ-025 SHALL, on RET with the stack not empty, pop, drive target = (top - prog_ctr) mod 2^D and jump_en=1.
REQ-026 SHALL, on RET with the stack empty, not jump and set stack_err.
REQ-027 SHALL, on HALT in RUN, drive jump_en=1 and target=0, and enter HALT on the next edge; done SHALL rise that edge.
REQ-028 SHALL ignore op while in IDLE or HALT; the stack SHALL be unchanged.
REQ-029 SHALL hold stack_err until reset; start SHALL NOT clear it.
REQ-030 SHALL perform all address arithmetic in D bits with wrap-around and no saturation.

Reset
REQ-031 SHALL, on reset, enter IDLE, empty the stack (pointer 0), and clear stack_err and done.
REQ-032 SHALL make reset dominate start and op in the same cycle, and SHALL abort RUN or HALT mid-program.
REQ-033 SHALL drive outputs after reset to jump_en=1, target=0, done=0, stack_err=0.

Structure
REQ-034 SHALL place br_op_t (3-bit enum), the state enum, and the 16-entry target LUT constant in a shared package br_pkg.
REQ-035 SHALL implement the return stack as one sub-module ret_stack, with push, pop, top, full, empty and a synchronous reset.
REQ-036 SHALL be synthesizable, with no latches and a single clock domain.

Verification
REQ-037 Start test SHALL check: reset, then start with prog_ctr=0x000 -> jump_en=1, target=0x000; next cycle state RUN; NOP -> jump_en=0.
REQ-038 Branch test SHALL check: LUT[3]=0x040, prog_ctr=0x010, BEQZ with zero=1 -> target=0x030, jump_en=1; with zero=0 -> jump_en=0.
REQ-039 Call/return test SHALL check: CALL idx 5 (LUT=0x100) at 0x020 pushes 0x021; RET at 0x105 -> target=0xF1C, jump_en=1.
REQ-040 Overflow/underflow test SHALL check: 5 CALLs with SDEPTH=4 -> 5th not taken, stack_err=1; from reset, RET -> jump_en=0, stack_err=1.
REQ-041 Halt/restart test SHALL check: HALT at 0x0FF -> done=1 and PC holds for 10 cycles; start -> target=0xF01, then RUN.
REQ-042 Reset-abort test SHALL check: reset mid-RUN with 2 stack entries -> IDLE, empty stack, done=0, stack_err=0.
